// File: rtl/hydra_pkg.sv
// Shared types and constants for the hydra transmit path.
package hydra_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POP       = 3'd1,
    CAPTURE   = 3'd2,
    WAIT_IDLE = 3'd3,
    LOAD      = 3'd4,
    GAP       = 3'd5,
    DROP      = 3'd6
  } sched_state_t;

  localparam int DEF_WIDTH = 64;

  // The direction flag sits just below the stop bit, i.e. the top payload bit.
  function automatic int dir_bit_of(input int width);
    return width - 2;
  endfunction

  localparam int DIR_BIT = dir_bit_of(DEF_WIDTH);

endpackage

// File: rtl/hydra_tx_sched.sv
// Transmit scheduler: pops one FIFO word at a time and loads it into the
// enabled UARTs once they are idle; drops and counts undeliverable packets.
//
//   state     | meaning
//   IDLE      | waiting for the FIFO to hold data
//   POP       | single-cycle FIFO read strobe
//   CAPTURE   | latch payload and destination mask, clear wait counter
//   WAIT_IDLE | wait for every targeted UART to go idle, bounded by TIMEOUT
//   LOAD      | single-cycle load strobe to the targeted UARTs
//   GAP       | dead cycle so UARTs can raise tx_busy
//   DROP      | packet discarded, drop counter bumped
module hydra_tx_sched
  import hydra_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-2:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic [3:0]       enable_piso_upstream,
  input  logic [3:0]       enable_piso_downstream,
  input  logic [3:0]       tx_busy,
  output logic [WIDTH-2:0] tx_data,
  output logic [3:0]       ld_tx_data_uart,
  output logic             sched_busy,
  output logic             timeout_flag,
  output logic [7:0]       drop_count
);

  localparam int         DirBit   = dir_bit_of(WIDTH);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  sched_state_t     state_q;
  logic [WIDTH-2:0] tx_data_q;
  logic [3:0]       mask_q;
  logic [3:0]       mask_d;
  logic [7:0]       wait_cnt_q;
  logic [7:0]       drop_cnt_q;
  logic             rd_en_q;
  logic [3:0]       ld_q;
  logic             timeout_q;

  assign mask_d = fifo_data[DirBit] ? enable_piso_downstream : enable_piso_upstream;

  // Strobes are registered alongside the state transition so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      mask_q     <= '0;
      wait_cnt_q <= '0;
      drop_cnt_q <= '0;
      rd_en_q    <= 1'b0;
      ld_q       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      rd_en_q   <= 1'b0;
      ld_q      <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
          end
        end
        POP: state_q <= CAPTURE;
        CAPTURE: begin
          tx_data_q  <= fifo_data;
          mask_q     <= mask_d;
          wait_cnt_q <= '0;
          state_q    <= (mask_d == 4'b0000) ? DROP : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          // Release is checked first so a same-edge release beats the timeout.
          if ((tx_busy & mask_q) == 4'b0000) begin
            state_q <= LOAD;
            ld_q    <= mask_q;
          end else if (wait_cnt_q == WaitLast) begin
            state_q   <= DROP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        LOAD: state_q <= GAP;
        GAP:  state_q <= IDLE;
        DROP: begin
          if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en      = rd_en_q;
  assign tx_data         = tx_data_q;
  assign ld_tx_data_uart = ld_q;
  assign sched_busy      = (state_q != IDLE);
  assign timeout_flag    = timeout_q;
  assign drop_count      = drop_cnt_q;

endmodule
